ex_alu: RTL and testbench

EX_ALU -- requirements
Module: ex_alu

---
 rtl/params_pkg.sv | 19 +
 rtl/ex_alu.sv | 148 ++++++++++++++
 tb/tb_ex_alu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared constants for the execute stage.
// ALU operation codes carried on alu_control_i.
package params_pkg;

   localparam logic [3:0] ADD_ALU_CONTROL       = 4'h0;
   localparam logic [3:0] SUB_ALU_CONTROL       = 4'h1;
   localparam logic [3:0] XOR_ALU_CONTROL       = 4'h2;
   localparam logic [3:0] OR_ALU_CONTROL        = 4'h3;
   localparam logic [3:0] AND_ALU_CONTROL       = 4'h4;
   localparam logic [3:0] L_SHIFT_ALU_CONTROL   = 4'h5;
   localparam logic [3:0] R_SHIFT_L_ALU_CONTROL = 4'h6;
   localparam logic [3:0] R_SHIFT_A_ALU_CONTROL = 4'h7;
   localparam logic [3:0] LT_ALU_CONTROL        = 4'h8;
   localparam logic [3:0] LTU_ALU_CONTROL       = 4'h9;
   localparam logic [3:0] GE_ALU_CONTROL        = 4'hA;
   localparam logic [3:0] GEU_ALU_CONTROL       = 4'hB;
   localparam logic [3:0] BNE_ALU_CONTROL       = 4'hC;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: execute-stage ALU with a bit-serial shifter and valid/ready handshakes.
// Ports: clk_i/rst_ni, valid_i/ready_o/alu_control_i/a_i/b_i/flush_i in, valid_o/ready_i/result_o/branch_cond_o out.
module ex_alu
   import params_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      alu_control_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            branch_cond_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [4:0]        cnt;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic [3:0]        op_ctl;
   logic [XLEN-1:0]   sh_nxt;
   logic              accept;
   logic              in_shift;

   assign ready_o = (state == IDLE) | ((state == DONE) & ready_i);
   assign accept  = valid_i & ready_o & ~flush_i;

   assign in_shift = (alu_control_i == L_SHIFT_ALU_CONTROL)
                   | (alu_control_i == R_SHIFT_L_ALU_CONTROL)
                   | (alu_control_i == R_SHIFT_A_ALU_CONTROL);

   // One-bit step of the latched operand; op_a doubles as the shift register.
   always_comb begin
      sh_nxt = op_a;
      unique case (op_ctl)
         L_SHIFT_ALU_CONTROL:   sh_nxt = {op_a[XLEN-2:0], 1'b0};
         R_SHIFT_L_ALU_CONTROL: sh_nxt = {1'b0, op_a[XLEN-1:1]};
         R_SHIFT_A_ALU_CONTROL: sh_nxt = {op_a[XLEN-1], op_a[XLEN-1:1]};
         default:               sh_nxt = op_a;
      endcase
   end

   // Result is decoded from the latched operands so it stays stable
   // while DONE waits on ready_i; shifts expose the shifted operand.
   always_comb begin
      result_o      = '0;
      branch_cond_o = 1'b0;
      unique case (op_ctl)
         ADD_ALU_CONTROL: result_o = op_a + op_b;
         SUB_ALU_CONTROL: begin
            result_o      = op_a - op_b;
            branch_cond_o = (op_a == op_b);
         end
         BNE_ALU_CONTROL: begin
            result_o      = op_a - op_b;
            branch_cond_o = (op_a != op_b);
         end
         LT_ALU_CONTROL: begin
            branch_cond_o = ($signed(op_a) < $signed(op_b));
            result_o      = {{(XLEN-1){1'b0}}, branch_cond_o};
         end
         LTU_ALU_CONTROL: begin
            branch_cond_o = (op_a < op_b);
            result_o      = {{(XLEN-1){1'b0}}, branch_cond_o};
         end
         GE_ALU_CONTROL: begin
            branch_cond_o = ($signed(op_a) >= $signed(op_b));
            result_o      = {{(XLEN-1){1'b0}}, branch_cond_o};
         end
         GEU_ALU_CONTROL: begin
            branch_cond_o = (op_a >= op_b);
            result_o      = {{(XLEN-1){1'b0}}, branch_cond_o};
         end
         XOR_ALU_CONTROL:       result_o = op_a ^ op_b;
         OR_ALU_CONTROL:        result_o = op_a | op_b;
         AND_ALU_CONTROL:       result_o = op_a & op_b;
         L_SHIFT_ALU_CONTROL:   result_o = op_a;
         R_SHIFT_L_ALU_CONTROL: result_o = op_a;
         R_SHIFT_A_ALU_CONTROL: result_o = op_a;
         default: begin
            result_o      = '0;
            branch_cond_o = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         valid_o <= 1'b0;
         cnt     <= '0;
         op_a    <= '0;
         op_b    <= '0;
         op_ctl  <= ADD_ALU_CONTROL;
      end else if (flush_i) begin
         state   <= IDLE;
         valid_o <= 1'b0;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op_a   <= a_i;
                  op_b   <= b_i;
                  op_ctl <= alu_control_i;
                  if (in_shift && (b_i[4:0] != 5'd0)) begin
                     state   <= SHIFT;
                     valid_o <= 1'b0;
                     cnt     <= b_i[4:0];
                  end else begin
                     state   <= DONE;
                     valid_o <= 1'b1;
                     cnt     <= '0;
                  end
               end else if ((state == DONE) && ready_i) begin
                  state   <= IDLE;
                  valid_o <= 1'b0;
               end
            end
            SHIFT: begin
               op_a <= sh_nxt;
               cnt  <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  state   <= DONE;
                  valid_o <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu.sv
// tb_ex_alu: directed bench for ex_alu.
// Hand-computed vectors checked with immediate assertions.
module tb_ex_alu;
   import params_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  alu_control_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        branch_cond_o;

   int total = 0;
   int bad   = 0;
   int lat;

   ex_alu #(.XLEN(32)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .alu_control_i (alu_control_i),
      .a_i           (a_i),
      .b_i           (b_i),
      .flush_i       (flush_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .result_o      (result_o),
      .branch_cond_o (branch_cond_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b);
      valid_i       = 1'b1;
      alu_control_i = ctl;
      a_i           = a;
      b_i           = b;
   endtask

   // Edges from the accept edge until valid_o rises, bounded.
   task automatic wait_done(output int n);
      n = 1;
      while (valid_o !== 1'b1 && n < 40) begin
         cyc();
         n++;
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] res,
                            input logic cond);
      chk({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
      chk({tag, "_res"}, result_o, res);
      chk({tag, "_cond"}, {31'b0, branch_cond_o}, {31'b0, cond});
   endtask

   initial begin
      rst_ni        = 1'b0;
      valid_i       = 1'b0;
      alu_control_i = 4'h0;
      a_i           = '0;
      b_i           = '0;
      flush_i       = 1'b0;
      ready_i       = 1'b1;
      cyc();
      cyc();
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_res", result_o, 32'd0);
      chk("rst_cond", {31'b0, branch_cond_o}, 32'd0);
      rst_ni = 1'b1;
      #1;
      chk("rst_ready", {31'b0, ready_o}, 32'd1);

      // ADD wraps
      drive(ADD_ALU_CONTROL, 32'hFFFF_FFFF, 32'd1);
      cyc();
      valid_i = 1'b0;
      check_out("add", 32'h0, 1'b0);
      cyc();
      chk("add_idle", {31'b0, valid_o}, 32'd0);

      // SRA by 4: 4 SHIFT cycles with ready_o low, then DONE
      drive(R_SHIFT_A_ALU_CONTROL, 32'h8000_0000, 32'd4);
      cyc();
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("sra_busy_ready", {31'b0, ready_o}, 32'd0);
         chk("sra_busy_valid", {31'b0, valid_o}, 32'd0);
         cyc();
      end
      check_out("sra", 32'hF800_0000, 1'b0);
      cyc();

      // GE then GEU back-to-back
      drive(GE_ALU_CONTROL, 32'hFFFF_FFFF, 32'd0);
      cyc();
      check_out("ge", 32'h0, 1'b0);
      drive(GEU_ALU_CONTROL, 32'hFFFF_FFFF, 32'd0);
      cyc();
      valid_i = 1'b0;
      check_out("geu", 32'h1, 1'b1);
      cyc();

      // SUB stalled by ready_i=0, pending op held off
      ready_i = 1'b0;
      drive(SUB_ALU_CONTROL, 32'd5, 32'd5);
      cyc();
      check_out("sub", 32'h0, 1'b1);
      drive(ADD_ALU_CONTROL, 32'd1, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("stall_ready", {31'b0, ready_o}, 32'd0);
         cyc();
         check_out("sub_hold", 32'h0, 1'b1);
      end
      ready_i = 1'b1;
      #1;
      chk("stall_release_ready", {31'b0, ready_o}, 32'd1);
      cyc();
      valid_i = 1'b0;
      check_out("add_after_stall", 32'd2, 1'b0);
      cyc();

      // SLL by 31 flushed in the 3rd SHIFT cycle
      drive(L_SHIFT_ALU_CONTROL, 32'd1, 32'd31);
      cyc();
      drive(ADD_ALU_CONTROL, 32'd7, 32'd7);
      valid_i = 1'b0;
      cyc();
      cyc();
      flush_i = 1'b1;
      valid_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush_valid", {31'b0, valid_o}, 32'd0);
      chk("flush_ready", {31'b0, ready_o}, 32'd1);
      cyc();
      chk("flush_no_ghost", {31'b0, valid_o}, 32'd0);

      // XOR then AND back-to-back
      drive(XOR_ALU_CONTROL, 32'hF0F0_F0F0, 32'hFF00_FF00);
      cyc();
      check_out("xor", 32'h0FF0_0FF0, 1'b0);
      drive(AND_ALU_CONTROL, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
      cyc();
      valid_i = 1'b0;
      check_out("and", 32'h3030_3030, 1'b0);
      cyc();
      chk("and_idle", {31'b0, valid_o}, 32'd0);

      // SRL with zero shift amount completes in one cycle
      drive(R_SHIFT_L_ALU_CONTROL, 32'h1234_5678, 32'hFFFF_FFE0);
      cyc();
      valid_i = 1'b0;
      check_out("srl0", 32'h1234_5678, 1'b0);
      cyc();

      // SLL by 3 latency and value
      drive(L_SHIFT_ALU_CONTROL, 32'h0000_0001, 32'd3);
      cyc();
      valid_i = 1'b0;
      wait_done(lat);
      chk("sll_lat", lat, 32'd4);
      check_out("sll", 32'h0000_0008, 1'b0);
      cyc();

      // SRL by 8
      drive(R_SHIFT_L_ALU_CONTROL, 32'h8000_0000, 32'd8);
      cyc();
      valid_i = 1'b0;
      wait_done(lat);
      chk("srl_lat", lat, 32'd9);
      check_out("srl", 32'h0080_0000, 1'b0);
      cyc();

      // Compares, BNE, OR, undefined code
      drive(LT_ALU_CONTROL, 32'hFFFF_FFFF, 32'd1);
      cyc();
      check_out("lt", 32'h1, 1'b1);
      drive(LTU_ALU_CONTROL, 32'hFFFF_FFFF, 32'd1);
      cyc();
      check_out("ltu", 32'h0, 1'b0);
      drive(BNE_ALU_CONTROL, 32'd3, 32'd5);
      cyc();
      check_out("bne", 32'hFFFF_FFFE, 1'b1);
      drive(OR_ALU_CONTROL, 32'h0000_00F0, 32'h0000_000F);
      cyc();
      check_out("or", 32'h0000_00FF, 1'b0);
      drive(4'hF, 32'd5, 32'd3);
      cyc();
      valid_i = 1'b0;
      check_out("undef", 32'h0, 1'b0);
      cyc();

      // Reset mid-shift discards the op
      drive(R_SHIFT_L_ALU_CONTROL, 32'hFFFF_FFFF, 32'd10);
      cyc();
      valid_i = 1'b0;
      cyc();
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_mid_res", result_o, 32'd0);
      cyc();
      rst_ni = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("rst_mid_no_pulse", {31'b0, valid_o}, 32'd0);
      end
      chk("rst_mid_ready", {31'b0, ready_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
